// File: rtl/ulpi_pkg.sv
// Shared ULPI constants: link state encoding, TX CMD prefixes and the
// PHY register addresses used by the register-access controller.
package ulpi_pkg;

    typedef enum logic [3:0] {
        PHY_RST,
        INIT_WAIT,
        IDLE,
        TXCMD,
        WDATA,
        STOP,
        RD_TURN,
        RD_DATA,
        RD_END
    } ulpi_state_e;

    // TX CMD prefixes for immediate register write / read
    localparam logic [7:0] TXCMD_REG_WRITE = 8'h80;
    localparam logic [7:0] TXCMD_REG_READ  = 8'hC0;

    // Immediate PHY register addresses
    localparam logic [5:0] REG_VENDOR_ID_LOW = 6'h00;
    localparam logic [5:0] REG_FUNC_CTRL     = 6'h04;
    localparam logic [5:0] REG_OTG_CTRL      = 6'h0A;

    // Builds the TX CMD byte for an immediate register access
    function automatic logic [7:0] txcmd_byte(input logic wr, input logic [5:0] addr);
        return (wr ? TXCMD_REG_WRITE : TXCMD_REG_READ) | {2'b00, addr};
    endfunction

endpackage

// File: rtl/ulpi_init_timer.sv
// Free-running cycle counter used to time the PHY reset pulse and the
// post-reset settling interval. Cleared on every controller state change.
module ulpi_init_timer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             CLKOUT,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear has priority over increment
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register, asynchronously cleared by reset
    always_ff @(posedge CLKOUT or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ulpi_reg_ctrl.sv
// ULPI link-side register access controller: sequences PHY reset and
// init, then performs immediate register writes/reads on request and
// aborts cleanly when the PHY takes the bus (DIR) mid-transfer.
module ulpi_reg_ctrl
    import ulpi_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = 60,
    parameter int unsigned INIT_CYCLES = 600
) (
    input  logic       CLKOUT,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_write,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       init_done,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_data_oe,
    output logic       ulpi_stp,
    output logic       phy_rst
);

    localparam int unsigned MAX_CYCLES = (RST_CYCLES > INIT_CYCLES) ? RST_CYCLES : INIT_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    ulpi_state_e state_q, state_d;
    logic        wr_q, wr_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        abort_q, abort_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        init_done_q, init_done_d;

    logic [CW-1:0] tmr_count;
    logic          tmr_en;
    logic          tmr_clr;
    logic          accept;

    assign tmr_en  = (state_q == PHY_RST) || (state_q == INIT_WAIT);
    assign tmr_clr = (state_d != state_q);

    ulpi_init_timer #(
        .WIDTH (CW)
    ) u_init_timer (
        .CLKOUT  (CLKOUT),
        .reset   (reset),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .count_o (tmr_count)
    );

    assign accept = req_valid && req_ready;

    // Next-state logic; aborted transfers reuse RD_END to wait for DIR low,
    // with abort_q selecting the error response on the way back to IDLE
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        abort_d     = abort_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        init_done_d = init_done_q;
        case (state_q)
            PHY_RST: begin
                if (tmr_count == CW'(RST_CYCLES - 1)) begin
                    state_d = INIT_WAIT;
                end
            end
            INIT_WAIT: begin
                if (tmr_count == CW'(INIT_CYCLES - 1)) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (accept) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    abort_d = 1'b0;
                    state_d = TXCMD;
                end
            end
            TXCMD: begin
                if (ulpi_dir) begin
                    abort_d = 1'b1;
                    state_d = RD_END;
                end else if (ulpi_nxt) begin
                    state_d = wr_q ? WDATA : RD_TURN;
                end
            end
            WDATA: begin
                if (ulpi_dir) begin
                    abort_d = 1'b1;
                    state_d = RD_END;
                end else if (ulpi_nxt) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
            RD_TURN: begin
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (ulpi_dir) begin
                    if (ulpi_nxt) begin
                        abort_d = 1'b1;
                    end else begin
                        rsp_rdata_d = ulpi_data_i;
                    end
                    state_d = RD_END;
                end
            end
            RD_END: begin
                if (!ulpi_dir) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = abort_q;
                end
            end
            default: begin
                state_d = PHY_RST;
            end
        endcase
    end

    // State and datapath registers, asynchronously reset into PHY_RST
    always_ff @(posedge CLKOUT or negedge reset) begin
        if (!reset) begin
            state_q     <= PHY_RST;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            abort_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            abort_q     <= abort_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            init_done_q <= init_done_d;
        end
    end

    // ULPI bus outputs; output enable drops combinationally as soon as DIR rises
    always_comb begin
        ulpi_data_o  = '0;
        ulpi_data_oe = 1'b0;
        ulpi_stp     = 1'b0;
        phy_rst      = 1'b0;
        req_ready    = 1'b0;
        case (state_q)
            PHY_RST: phy_rst = 1'b1;
            IDLE:    req_ready = !ulpi_dir;
            TXCMD: begin
                ulpi_data_o  = txcmd_byte(wr_q, addr_q);
                ulpi_data_oe = !ulpi_dir;
            end
            WDATA: begin
                ulpi_data_o  = wdata_q;
                ulpi_data_oe = !ulpi_dir;
            end
            STOP: begin
                ulpi_stp     = 1'b1;
                ulpi_data_oe = !ulpi_dir;
            end
            default: begin
                ulpi_data_o = '0;
            end
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Directed bench for ulpi_reg_ctrl: init sequence, register write/read,
// DIR aborts, back-to-back requests and reset during a transfer.
module tb_ulpi_reg_ctrl;

    logic       CLKOUT;
    logic       reset;
    logic       req_valid;
    logic       req_write;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       init_done;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic [7:0] ulpi_data_i;
    logic [7:0] ulpi_data_o;
    logic       ulpi_data_oe;
    logic       ulpi_stp;
    logic       phy_rst;

    int errors = 0;
    int checks = 0;

    ulpi_reg_ctrl #(
        .RST_CYCLES  (4),
        .INIT_CYCLES (8)
    ) dut (
        .CLKOUT       (CLKOUT),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_done    (init_done),
        .ulpi_dir     (ulpi_dir),
        .ulpi_nxt     (ulpi_nxt),
        .ulpi_data_i  (ulpi_data_i),
        .ulpi_data_o  (ulpi_data_o),
        .ulpi_data_oe (ulpi_data_oe),
        .ulpi_stp     (ulpi_stp),
        .phy_rst      (phy_rst)
    );

    initial CLKOUT = 1'b0;
    always #5 CLKOUT = ~CLKOUT;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic go();
        @(posedge CLKOUT);
        #1;
    endtask

    // Release reset and measure phy_rst width, init wait and stray responses
    task automatic run_init(output int nr, output int ni, output int nv);
        go();
        reset = 1'b1;
        #1;
        nr = 0;
        ni = 0;
        nv = 0;
        while (phy_rst && nr < 100) begin
            nr++;
            nv += int'(rsp_valid);
            go();
            #1;
        end
        while (!init_done && ni < 200) begin
            ni++;
            nv += int'(rsp_valid);
            go();
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nr, ni, nv, lat;
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        ulpi_dir    = 1'b0;
        ulpi_nxt    = 1'b0;
        ulpi_data_i = '0;
        #2;
        check("rst_phy_rst",   16'(phy_rst), 16'h1);
        check("rst_oe",        16'(ulpi_data_oe), 16'h0);
        check("rst_data_o",    16'(ulpi_data_o), 16'h00);
        check("rst_stp",       16'(ulpi_stp), 16'h0);
        check("rst_ready",     16'(req_ready), 16'h0);
        check("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        check("rst_rsp_err",   16'(rsp_err), 16'h0);
        check("rst_rdata",     16'(rsp_rdata), 16'h00);
        check("rst_init_done", 16'(init_done), 16'h0);

        run_init(nr, ni, nv);
        check("init_rst_cycles",  16'(nr), 16'd4);
        check("init_wait_cycles", 16'(ni), 16'd8);
        check("init_no_rsp",      16'(nv), 16'd0);
        check("init_ready",       16'(req_ready), 16'h1);
        check("init_phy_rst_low", 16'(phy_rst), 16'h0);

        // Write OTG control 0x0A <= 0x00, NXT one cycle into TXCMD
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h0A; req_wdata = 8'h00; #1;
        check("wr_ready", 16'(req_ready), 16'h1);
        go(); req_valid = 1'b0; ulpi_nxt = 1'b0; #1;
        check("wr_txcmd",      16'(ulpi_data_o), 16'h8A);
        check("wr_txcmd_oe",   16'(ulpi_data_oe), 16'h1);
        go(); ulpi_nxt = 1'b1; #1;
        check("wr_txcmd_hold", 16'(ulpi_data_o), 16'h8A);
        go(); #1;
        check("wr_wdata",      16'(ulpi_data_o), 16'h00);
        check("wr_wdata_oe",   16'(ulpi_data_oe), 16'h1);
        check("wr_wdata_stp",  16'(ulpi_stp), 16'h0);
        go(); ulpi_nxt = 1'b0; #1;
        check("wr_stop_stp",   16'(ulpi_stp), 16'h1);
        check("wr_stop_data",  16'(ulpi_data_o), 16'h00);
        check("wr_stop_rsp",   16'(rsp_valid), 16'h0);
        go(); #1;
        check("wr_rsp_valid",  16'(rsp_valid), 16'h1);
        check("wr_rsp_err",    16'(rsp_err), 16'h0);
        check("wr_stp_off",    16'(ulpi_stp), 16'h0);
        go(); #1;
        check("wr_rsp_pulse",  16'(rsp_valid), 16'h0);

        // Write function control 0x04 <= 0x55 with NXT immediately high
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h04; req_wdata = 8'h55; #1;
        go(); req_valid = 1'b0; ulpi_nxt = 1'b1; #1;
        lat = 1;
        check("lat_txcmd", 16'(ulpi_data_o), 16'h84);
        while (!rsp_valid && lat < 50) begin
            go(); #1;
            lat++;
        end
        ulpi_nxt = 1'b0;
        check("wr_latency", 16'(lat), 16'd4);

        // Read vendor ID low, PHY returns 0x24
        go();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h00; #1;
        check("rd_ready", 16'(req_ready), 16'h1);
        go(); req_valid = 1'b0; ulpi_nxt = 1'b1; #1;
        check("rd_txcmd",    16'(ulpi_data_o), 16'hC0);
        check("rd_txcmd_oe", 16'(ulpi_data_oe), 16'h1);
        go(); ulpi_nxt = 1'b0; ulpi_dir = 1'b1; #1;
        check("rd_turn_oe",  16'(ulpi_data_oe), 16'h0);
        go(); ulpi_data_i = 8'h24; #1;
        check("rd_data_oe",  16'(ulpi_data_oe), 16'h0);
        go(); ulpi_dir = 1'b0; ulpi_data_i = 8'h00; #1;
        check("rd_end_rsp",  16'(rsp_valid), 16'h0);
        go(); #1;
        check("rd_rsp_valid", 16'(rsp_valid), 16'h1);
        check("rd_rdata",     16'(rsp_rdata), 16'h24);
        check("rd_err",       16'(rsp_err), 16'h0);

        // DIR rises in TXCMD before NXT
        go();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h04; req_wdata = 8'h33; #1;
        go(); req_valid = 1'b0; #1;
        check("ab_txcmd_oe", 16'(ulpi_data_oe), 16'h1);
        go(); ulpi_dir = 1'b1; #1;
        check("ab_oe_drop",  16'(ulpi_data_oe), 16'h0);
        check("ab_no_stp",   16'(ulpi_stp), 16'h0);
        go(); #1;
        check("ab_wait_stp", 16'(ulpi_stp), 16'h0);
        check("ab_wait_rsp", 16'(rsp_valid), 16'h0);
        go(); ulpi_dir = 1'b0; #1;
        check("ab_end_rsp",  16'(rsp_valid), 16'h0);
        go(); #1;
        check("ab_rsp_valid", 16'(rsp_valid), 16'h1);
        check("ab_rsp_err",   16'(rsp_err), 16'h1);
        check("ab_rdata",     16'(rsp_rdata), 16'h24);

        // NXT and DIR together in TXCMD: DIR wins
        go();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h0A; #1;
        go(); req_valid = 1'b0; ulpi_dir = 1'b1; ulpi_nxt = 1'b1; #1;
        check("tie_oe", 16'(ulpi_data_oe), 16'h0);
        go(); ulpi_dir = 1'b0; ulpi_nxt = 1'b0; #1;
        check("tie_end_rsp", 16'(rsp_valid), 16'h0);
        go(); #1;
        check("tie_rsp_valid", 16'(rsp_valid), 16'h1);
        check("tie_rsp_err",   16'(rsp_err), 16'h1);

        // RX packet (DIR and NXT) where register data was expected
        go();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h04; #1;
        go(); req_valid = 1'b0; ulpi_nxt = 1'b1; #1;
        go(); ulpi_nxt = 1'b0; ulpi_dir = 1'b1; #1;
        go(); ulpi_nxt = 1'b1; ulpi_data_i = 8'h99; #1;
        go(); ulpi_nxt = 1'b0; ulpi_dir = 1'b0; ulpi_data_i = 8'h00; #1;
        check("rx_end_rsp", 16'(rsp_valid), 16'h0);
        go(); #1;
        check("rx_rsp_valid", 16'(rsp_valid), 16'h1);
        check("rx_rsp_err",   16'(rsp_err), 16'h1);
        check("rx_rdata",     16'(rsp_rdata), 16'h24);

        // Back-to-back write then read with req_valid held
        go();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h04; req_wdata = 8'hA5; #1;
        check("b2b_ready1", 16'(req_ready), 16'h1);
        go(); req_write = 1'b0; req_addr = 6'h0A; ulpi_nxt = 1'b1; #1;
        check("b2b_busy_tx", 16'(req_ready), 16'h0);
        check("b2b_txcmd",   16'(ulpi_data_o), 16'h84);
        go(); #1;
        check("b2b_busy_wd", 16'(req_ready), 16'h0);
        check("b2b_wdata",   16'(ulpi_data_o), 16'hA5);
        go(); ulpi_nxt = 1'b0; #1;
        check("b2b_busy_st", 16'(req_ready), 16'h0);
        check("b2b_stp",     16'(ulpi_stp), 16'h1);
        go(); #1;
        check("b2b_rsp1",     16'(rsp_valid), 16'h1);
        check("b2b_rsp1_err", 16'(rsp_err), 16'h0);
        check("b2b_ready2",   16'(req_ready), 16'h1);
        go(); req_valid = 1'b0; ulpi_nxt = 1'b1; #1;
        check("b2b_rd_txcmd", 16'(ulpi_data_o), 16'hCA);
        check("b2b_rsp_gap",  16'(rsp_valid), 16'h0);
        go(); ulpi_nxt = 1'b0; ulpi_dir = 1'b1; #1;
        go(); ulpi_data_i = 8'h5A; #1;
        go(); ulpi_dir = 1'b0; ulpi_data_i = 8'h00; #1;
        check("b2b_rd_end", 16'(rsp_valid), 16'h0);
        go(); #1;
        check("b2b_rsp2",       16'(rsp_valid), 16'h1);
        check("b2b_rsp2_rdata", 16'(rsp_rdata), 16'h5A);
        check("b2b_rsp2_err",   16'(rsp_err), 16'h0);
        go(); #1;
        check("b2b_rsp2_pulse", 16'(rsp_valid), 16'h0);

        // Reset asserted while in WDATA
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h0A; req_wdata = 8'h11; #1;
        go(); req_valid = 1'b0; ulpi_nxt = 1'b1; #1;
        go(); ulpi_nxt = 1'b0; #1;
        check("mid_wdata",    16'(ulpi_data_o), 16'h11);
        check("mid_wdata_oe", 16'(ulpi_data_oe), 16'h1);
        reset = 1'b0; #1;
        check("mid_rst_oe",      16'(ulpi_data_oe), 16'h0);
        check("mid_rst_phy_rst", 16'(phy_rst), 16'h1);
        check("mid_rst_data",    16'(ulpi_data_o), 16'h00);
        check("mid_rst_init",    16'(init_done), 16'h0);
        check("mid_rst_ready",   16'(req_ready), 16'h0);
        check("mid_rst_rsp",     16'(rsp_valid), 16'h0);
        run_init(nr, ni, nv);
        check("re_rst_cycles",  16'(nr), 16'd4);
        check("re_wait_cycles", 16'(ni), 16'd8);
        check("re_no_rsp",      16'(nv), 16'd0);
        check("re_ready",       16'(req_ready), 16'h1);
        check("re_rdata_clr",   16'(rsp_rdata), 16'h00);

        go();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ulpi_reg_ctrl.md
ULPI_REG_CTRL -- requirements
Module: ulpi_reg_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 60, meaning CLKOUT cycles phy_rst is held high after reset release.
REQ-002 SHALL have parameter INIT_CYCLES, default 600, meaning CLKOUT cycles waited after phy_rst deassert before accepting requests.
REQ-003 SHALL have port CLKOUT  in  1  60 MHz ULPI clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_valid in 1, req_write in 1 (1=write, 0=read), req_addr in 6 (immediate register address), req_wdata in 8: the requester command.
REQ-006 SHALL have port req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-007 SHALL have ports rsp_valid out 1 (one-cycle completion pulse), rsp_rdata out 8 (read data), rsp_err out 1 (aborted by PHY).
REQ-008 SHALL have port init_done  out  1  high once the PHY reset/init sequence is complete.
REQ-009 SHALL have ports ulpi_dir in 1, ulpi_nxt in 1, ulpi_data_i in 8, ulpi_data_o out 8, ulpi_data_oe out 1, ulpi_stp out 1, phy_rst out 1.

Function
REQ-010 SHALL implement states PHY_RST, INIT_WAIT, IDLE, TXCMD, WDATA, STOP, RD_TURN, RD_DATA, RD_END.
REQ-011 PHY_RST: phy_rst=1 for RST_CYCLES cycles, then INIT_WAIT with phy_rst=0; after INIT_CYCLES cycles go to IDLE and set init_done=1 (sticky until reset).
REQ-012 req_ready SHALL be 1 only in IDLE with ulpi_dir=0; acceptance latches write/addr/wdata and moves to TXCMD next cycle.
REQ-013 ulpi_data_oe SHALL be 1 only in TXCMD, WDATA, STOP and only while ulpi_dir=0; otherwise 0 (link never drives while DIR=1).
REQ-014 ulpi_data_o SHALL be 0x00 whenever not in TXCMD/WDATA (ULPI idle).
REQ-015 TXCMD: drive 0x80|addr (write) or 0xC0|addr (read), held until a cycle with ulpi_nxt=1; write -> WDATA, read -> RD_TURN.
REQ-016 WDATA: drive latched wdata, held until ulpi_nxt=1, then STOP.
REQ-017 STOP: ulpi_stp=1, ulpi_data_o=0x00 for exactly one cycle; then IDLE with rsp_valid=1, rsp_err=0.
REQ-018 RD_TURN: one turnaround cycle with oe=0, expecting ulpi_dir=1; RD_DATA: capture ulpi_data_i into rsp_rdata on first cycle with ulpi_dir=1 and ulpi_nxt=0; RD_END: wait for ulpi_dir=0, then IDLE with rsp_valid=1, rsp_err=0.
REQ-019 If ulpi_dir rises in TXCMD or WDATA before the command/data byte is accepted (RX CMD), the transfer SHALL abort: oe=0, stp=0, wait for ulpi_dir=0, then IDLE with rsp_valid=1, rsp_err=1, rsp_rdata unchanged.
REQ-020 If ulpi_dir=1 and ulpi_nxt=1 in RD_DATA (RX packet instead of register data), SHALL abort per REQ-019.
REQ-021 Same-cycle ulpi_nxt=1 and ulpi_dir rising in TXCMD SHALL be treated as abort (DIR wins).
REQ-022 ulpi_stp SHALL be 1 only in STOP; rsp_valid SHALL be a single-cycle pulse per accepted request; exactly one response per request.
REQ-023 Latency SHALL be: write with NXT immediately high = 4 cycles accept-to-rsp_valid; read with immediate DIR turnaround = 5 cycles.

Reset
REQ-024 On reset low, SHALL asynchronously enter PHY_RST with phy_rst=1, ulpi_data_oe=0, ulpi_data_o=0x00, ulpi_stp=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0x00, init_done=0, counters cleared.
REQ-025 Reset mid-transfer SHALL drop the transfer with no response and restart the full PHY init sequence.

Structure
REQ-026 TXCMD prefixes (0x80 write, 0xC0 read), ULPI register addresses (vendor ID low 0x00, OTG control 0x0A, function control 0x04) and the state encoding SHALL live in shared package ulpi_pkg.
REQ-027 SHALL be a single module; the init counter MAY be a sub-module ulpi_init_timer.

Verification
REQ-028 Reset then release, RST_CYCLES=4, INIT_CYCLES=8 -> phy_rst high 4 cycles, init_done rises 8 cycles later, req_ready=1.
REQ-029 Write addr 0x0A data 0x00, PHY NXT high one cycle after TXCMD -> data_o 0x8A then 0x00, stp pulse 1 cycle, rsp_valid=1, rsp_err=0.
REQ-030 Read addr 0x00, PHY returns 0x24 after turnaround -> data_o 0xC0, oe drops on DIR, rsp_rdata=0x24, rsp_valid=1.
REQ-031 DIR raised during TXCMD before NXT -> oe=0 same cycle, no stp, after DIR low rsp_valid=1, rsp_err=1.
REQ-032 Back-to-back write then read with req_valid held -> second request accepted only after first rsp_valid, both responses in order.
REQ-033 Reset asserted in WDATA -> oe=0 and phy_rst=1 immediately, no rsp_valid, init sequence repeats.
